// File: rtl/fifo_sync_buffer.sv
// fifo_sync_buffer
//
// Single-clock circular-buffer FIFO. It sits between a registered read
// controller and the data consumer. Reads return data one cycle after the
// accepted strobe, together with a one-cycle valid pulse. Status flags are
// computed from the next-state occupancy and registered, so they are
// current on the same edge that changes the count. A write while full or a
// read while empty is dropped safely and reported with a one-cycle pulse.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rest       asynchronous active-high reset
//   i_wen        write strobe, one word per cycle
//   i_wdata      write data, sampled with i_wen
//   i_ren        read strobe from the read controller
//   o_rdata      read data, valid while o_rvalid is high
//   o_rvalid     one-cycle pulse per accepted read
//   o_empty      occupancy == 0
//   o_full       occupancy == DEPTH
//   o_afull      occupancy >= AFULL_LEVEL
//   o_count      occupancy, 0..DEPTH
//   o_overflow   one-cycle pulse, write dropped
//   o_underflow  one-cycle pulse, read ignored

module fifo_sync_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rest,
  input  logic                  i_wen,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_ren,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rvalid,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_afull,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_AFULL = (ADDR_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wp_q, wp_d;
  logic [ADDR_WIDTH-1:0] rp_q, rp_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  afull_q, afull_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic ra;
  logic wa;

  // A read while full frees a slot on the same edge, so the write is
  // accepted. The read side never looks at the write: an empty FIFO
  // ignores the read even if a write arrives together with it.
  assign ra = i_ren & ~empty_q;
  assign wa = i_wen & (~full_q | ra);

  always_comb begin
    wp_d     = wp_q;
    rp_d     = rp_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    ovf_d    = i_wen & ~wa;
    udf_d    = i_ren & empty_q;

    if (wa) begin
      wp_d = wp_q + PTR_ONE;
    end
    if (ra) begin
      rp_d     = rp_q + PTR_ONE;
      rdata_d  = mem[rp_q];
      rvalid_d = 1'b1;
    end

    case ({wa, ra})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_FULL);
    afull_d = (count_d >= CNT_AFULL);
  end

  always_ff @(posedge i_clk or posedge i_rest) begin
    if (i_rest) begin
      wp_q     <= '0;
      rp_q     <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately left without reset; clearing the pointers
  // discards its contents logically. When full and reading, wp == rp, and
  // the read above samples the old word before this write replaces it.
  always_ff @(posedge i_clk) begin
    if (wa) begin
      mem[wp_q] <= i_wdata;
    end
  end

  assign o_rdata     = rdata_q;
  assign o_rvalid    = rvalid_q;
  assign o_empty     = empty_q;
  assign o_full      = full_q;
  assign o_afull     = afull_q;
  assign o_count     = count_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = udf_q;

endmodule

// File: tb/tb_fifo_sync_buffer.sv
module tb_fifo_sync_buffer;

  logic       i_clk = 1'b0;
  logic       i_rest;
  logic       i_wen;
  logic [7:0] i_wdata;
  logic       i_ren;
  logic [7:0] o_rdata;
  logic       o_rvalid;
  logic       o_empty;
  logic       o_full;
  logic       o_afull;
  logic [4:0] o_count;
  logic       o_overflow;
  logic       o_underflow;

  int total = 0;
  int bad   = 0;

  fifo_sync_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_LEVEL(12)) dut (
    .i_clk      (i_clk),
    .i_rest     (i_rest),
    .i_wen      (i_wen),
    .i_wdata    (i_wdata),
    .i_ren      (i_ren),
    .o_rdata    (o_rdata),
    .o_rvalid   (o_rvalid),
    .o_empty    (o_empty),
    .o_full     (o_full),
    .o_afull    (o_afull),
    .o_count    (o_count),
    .o_overflow (o_overflow),
    .o_underflow(o_underflow)
  );

  always #5 i_clk = ~i_clk;

  // Advance one rising edge, then settle 1 ns so outputs are sampled off the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rest = 1'b1; i_wen = 1'b0; i_ren = 1'b0; i_wdata = 8'h00;
    #2;
    total++;
    if (o_count !== 5'd0 || o_empty !== 1'b1 || o_full !== 1'b0 || o_afull !== 1'b0 ||
        o_rvalid !== 1'b0 || o_rdata !== 8'h00 || o_overflow !== 1'b0 || o_underflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_state count=%0d empty=%b full=%b afull=%b rvalid=%b rdata=%h ovf=%b udf=%b (want 0 1 0 0 0 00 0 0)",
               o_count, o_empty, o_full, o_afull, o_rvalid, o_rdata, o_overflow, o_underflow);
    end
    repeat (2) tick();
    i_rest = 1'b0;
    tick();
    total++;
    if (o_empty !== 1'b1 || o_count !== 5'd0) begin
      bad++;
      $display("FAIL reset_release empty=%b count=%0d want 1 0", o_empty, o_count);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      i_wen = 1'b1; i_wdata = i[7:0];
      tick();
      total++;
      if (o_count !== 5'(i + 1) || o_afull !== (i + 1 >= 12) || o_full !== (i == 15) || o_empty !== 1'b0) begin
        bad++;
        $display("FAIL fill_flags i=%0d count=%0d afull=%b full=%b empty=%b want %0d %b %b 0",
                 i, o_count, o_afull, o_full, o_empty, i + 1, (i + 1 >= 12), (i == 15));
      end
    end
    i_wdata = 8'hAA;
    tick();
    i_wen = 1'b0;
    total++;
    if (o_overflow !== 1'b1 || o_count !== 5'd16 || o_full !== 1'b1) begin
      bad++;
      $display("FAIL overflow ovf=%b count=%0d full=%b want 1 16 1", o_overflow, o_count, o_full);
    end
    tick();
    total++;
    if (o_overflow !== 1'b0 || o_count !== 5'd16) begin
      bad++;
      $display("FAIL overflow_pulse ovf=%b count=%0d want 0 16", o_overflow, o_count);
    end
    for (int i = 0; i < 16; i++) begin
      i_ren = 1'b1;
      tick();
      total++;
      if (o_rvalid !== 1'b1 || o_rdata !== i[7:0] || o_count !== 5'(15 - i) || o_empty !== (i == 15) ||
          o_full !== 1'b0) begin
        bad++;
        $display("FAIL drain i=%0d rvalid=%b rdata=%h count=%0d empty=%b full=%b want 1 %h %0d %b 0",
                 i, o_rvalid, o_rdata, o_count, o_empty, o_full, i[7:0], 15 - i, (i == 15));
      end
    end
    i_ren = 1'b0;
    tick();
    total++;
    if (o_rvalid !== 1'b0 || o_underflow !== 1'b0 || o_rdata !== 8'h0F) begin
      bad++;
      $display("FAIL drain_idle rvalid=%b udf=%b rdata=%h want 0 0 0f", o_rvalid, o_underflow, o_rdata);
    end
  endtask

  task automatic test_underflow();
    i_ren = 1'b1;
    tick();
    i_ren = 1'b0;
    total++;
    if (o_underflow !== 1'b1 || o_rvalid !== 1'b0 || o_count !== 5'd0 || o_empty !== 1'b1) begin
      bad++;
      $display("FAIL underflow udf=%b rvalid=%b count=%0d empty=%b want 1 0 0 1",
               o_underflow, o_rvalid, o_count, o_empty);
    end
    tick();
    total++;
    if (o_underflow !== 1'b0) begin
      bad++;
      $display("FAIL underflow_pulse udf=%b want 0", o_underflow);
    end
  endtask

  task automatic test_simul_full();
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) begin
      i_wen = 1'b1; i_wdata = 8'h80 + i[7:0];
      tick();
    end
    i_wdata = 8'h55; i_ren = 1'b1;
    tick();
    i_wen = 1'b0;
    total++;
    if (o_rvalid !== 1'b1 || o_rdata !== 8'h80 || o_count !== 5'd16 || o_overflow !== 1'b0 || o_full !== 1'b1) begin
      bad++;
      $display("FAIL simul_full rvalid=%b rdata=%h count=%0d ovf=%b full=%b want 1 80 16 0 1",
               o_rvalid, o_rdata, o_count, o_overflow, o_full);
    end
    for (int i = 0; i < 16; i++) begin
      exp = (i == 15) ? 8'h55 : 8'h81 + i[7:0];
      tick();
      total++;
      if (o_rvalid !== 1'b1 || o_rdata !== exp || o_count !== 5'(15 - i)) begin
        bad++;
        $display("FAIL simul_full_drain i=%0d rvalid=%b rdata=%h count=%0d want 1 %h %0d",
                 i, o_rvalid, o_rdata, o_count, exp, 15 - i);
      end
    end
    i_ren = 1'b0;
    tick();
  endtask

  task automatic test_simul_empty();
    i_wen = 1'b1; i_wdata = 8'h33; i_ren = 1'b1;
    tick();
    i_wen = 1'b0; i_ren = 1'b0;
    total++;
    if (o_underflow !== 1'b1 || o_rvalid !== 1'b0 || o_count !== 5'd1 || o_empty !== 1'b0) begin
      bad++;
      $display("FAIL simul_empty udf=%b rvalid=%b count=%0d empty=%b want 1 0 1 0",
               o_underflow, o_rvalid, o_count, o_empty);
    end
    i_ren = 1'b1;
    tick();
    i_ren = 1'b0;
    total++;
    if (o_rvalid !== 1'b1 || o_rdata !== 8'h33 || o_count !== 5'd0 || o_empty !== 1'b1 || o_underflow !== 1'b0) begin
      bad++;
      $display("FAIL simul_empty_read rvalid=%b rdata=%h count=%0d empty=%b udf=%b want 1 33 0 1 0",
               o_rvalid, o_rdata, o_count, o_empty, o_underflow);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) begin
      i_wen = 1'b1; i_wdata = 8'hC0 + i[7:0];
      tick();
    end
    i_ren = 1'b1;
    for (int k = 0; k < 40; k++) begin
      i_wdata = 8'hC3 + k[7:0];
      tick();
      total++;
      if (o_rvalid !== 1'b1 || o_rdata !== 8'hC0 + k[7:0] || o_count !== 5'd3) begin
        bad++;
        $display("FAIL wrap k=%0d rvalid=%b rdata=%h count=%0d want 1 %h 3",
                 k, o_rvalid, o_rdata, o_count, 8'hC0 + k[7:0]);
      end
    end
    i_wen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (o_rdata !== 8'hE8 + k[7:0] || o_count !== 5'(2 - k)) begin
        bad++;
        $display("FAIL wrap_drain k=%0d rdata=%h count=%0d want %h %0d",
                 k, o_rdata, o_count, 8'hE8 + k[7:0], 2 - k);
      end
    end
    i_ren = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 5; i++) begin
      i_wen = 1'b1; i_wdata = 8'h10 + i[7:0];
      tick();
    end
    i_wdata = 8'h15; i_ren = 1'b1;
    tick();
    total++;
    if (o_rvalid !== 1'b1 || o_rdata !== 8'h10 || o_count !== 5'd5) begin
      bad++;
      $display("FAIL burst_pre rvalid=%b rdata=%h count=%0d want 1 10 5", o_rvalid, o_rdata, o_count);
    end
    #3;
    i_rest = 1'b1; i_wen = 1'b0; i_ren = 1'b0;
    #1;
    total++;
    if (o_count !== 5'd0 || o_empty !== 1'b1 || o_rvalid !== 1'b0 || o_rdata !== 8'h00 || o_afull !== 1'b0) begin
      bad++;
      $display("FAIL async_reset count=%0d empty=%b rvalid=%b rdata=%h afull=%b want 0 1 0 00 0",
               o_count, o_empty, o_rvalid, o_rdata, o_afull);
    end
    #1;
    i_rest = 1'b0;
    tick();
    i_wen = 1'b1; i_wdata = 8'h77;
    tick();
    i_wen = 1'b0; i_ren = 1'b1;
    tick();
    i_ren = 1'b0;
    total++;
    if (o_rvalid !== 1'b1 || o_rdata !== 8'h77 || o_count !== 5'd0 || o_underflow !== 1'b0) begin
      bad++;
      $display("FAIL post_reset rvalid=%b rdata=%h count=%0d udf=%b want 1 77 0 0",
               o_rvalid, o_rdata, o_count, o_underflow);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_underflow();
    test_simul_full();
    test_simul_empty();
    test_wrap();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
